// File: rtl/debug_run_controller.sv
// debug_run_controller
//
// Command sequencer between the UART receive path and the pipeline.
// It decodes host command bytes (continuous run, single step, pipeline
// reset), gates the pipeline clock-enable, and drives the pipeline reset.
// After every step or halt it streams a fixed-length dump of debug bytes
// back through the UART transmitter, using a byte-addressed read port.
//
// Ports:
//   clk          in   single clock, all state updates on posedge
//   reset        in   asynchronous active-high reset
//   rx_data[7:0] in   received byte, valid while rx_done=1
//   rx_done      in   one-cycle strobe per received byte
//   halt         in   level, pipeline has retired a halt instruction
//   pipe_enable  out  pipeline clock-enable
//   pipe_reset   out  pipeline synchronous reset request
//   dump_addr    out  debug read address (byte index)
//   dump_data    in   debug read data, combinational from dump_addr
//   tx_start     out  one-cycle request to send tx_data
//   tx_data      out  byte to transmit, held from tx_start until tx_done
//   tx_done      in   one-cycle pulse when the transmitter finishes a byte
//   busy         out  high whenever the sequencer is not idle
module debug_run_controller #(
  parameter logic [7:0] CMD_CONT   = 8'h63,
  parameter logic [7:0] CMD_STEP   = 8'h73,
  parameter logic [7:0] CMD_RST    = 8'h72,
  parameter int         DUMP_BYTES = 16,
  parameter int         RST_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       halt,
  output logic       pipe_enable,
  output logic       pipe_reset,
  output logic [7:0] dump_addr,
  input  logic [7:0] dump_data,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP,
    PRST,
    DLOAD,
    DSEND,
    DWAIT
  } state_t;

  // Terminal values are compared against 8-bit counters; DUMP_BYTES up to
  // 256 still fits because the compare is made at the last index.
  localparam logic [7:0] LAST_IDX = 8'(DUMP_BYTES - 1);
  localparam logic [7:0] LAST_RST = 8'(RST_CYCLES - 1);

  state_t     state, state_n;
  logic [7:0] idx, idx_n;
  logic [7:0] rst_cnt, rst_cnt_n;
  logic [7:0] tx_data_q, tx_data_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 8'd0;
      rst_cnt   <= 8'd0;
      tx_data_q <= 8'd0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      rst_cnt   <= rst_cnt_n;
      tx_data_q <= tx_data_n;
    end
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    rst_cnt_n   = rst_cnt;
    tx_data_n   = tx_data_q;
    pipe_enable = 1'b0;
    pipe_reset  = 1'b0;
    tx_start    = 1'b0;

    unique case (state)
      IDLE: begin
        if (rx_done) begin
          if (rx_data == CMD_CONT) begin
            state_n = RUN;
          end else if (rx_data == CMD_STEP) begin
            state_n = STEP;
          end else if (rx_data == CMD_RST) begin
            state_n   = PRST;
            rst_cnt_n = 8'd0;
          end
        end
      end

      RUN: begin
        // Halt masks the enable in the very cycle it is seen, so the
        // pipeline never advances past the halting instruction. A reset
        // command wins over a simultaneous halt and suppresses the dump.
        pipe_enable = !halt;
        if (rx_done && (rx_data == CMD_RST)) begin
          state_n   = PRST;
          rst_cnt_n = 8'd0;
        end else if (halt) begin
          state_n = DLOAD;
          idx_n   = 8'd0;
        end
      end

      STEP: begin
        pipe_enable = 1'b1;
        state_n     = DLOAD;
        idx_n       = 8'd0;
      end

      PRST: begin
        pipe_reset = 1'b1;
        if (rst_cnt == LAST_RST) begin
          state_n   = IDLE;
          rst_cnt_n = 8'd0;
        end else begin
          rst_cnt_n = rst_cnt + 8'd1;
        end
      end

      DLOAD: begin
        // The read port is combinational, so the byte is captured here and
        // held in tx_data for the whole transmitter handshake.
        tx_data_n = dump_data;
        state_n   = DSEND;
      end

      DSEND: begin
        tx_start = 1'b1;
        state_n  = DWAIT;
      end

      DWAIT: begin
        if (tx_done) begin
          if (idx == LAST_IDX) begin
            state_n = IDLE;
          end else begin
            idx_n   = idx + 8'd1;
            state_n = DLOAD;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign dump_addr = idx;
  assign tx_data   = tx_data_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_debug_run_controller.sv
// tb_debug_run_controller
//
// Self-checking bench for debug_run_controller. A default-parameter
// instance is exercised through step, run/halt, pipeline reset, ignored
// input and mid-dump async reset scenarios; a second instance built with
// DUMP_BYTES=1 and RST_CYCLES=1 covers the minimum-size boundary.
// Expected dump bytes are pushed to a queue when a command is issued and
// popped by a monitor whenever the DUT raises tx_start.
module tb_debug_run_controller;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       halt;
  logic       pipe_enable;
  logic       pipe_reset;
  logic [7:0] dump_addr;
  logic [7:0] dump_data;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       busy;

  logic [7:0] s_rx_data;
  logic       s_rx_done;
  logic       s_halt;
  logic       s_pipe_enable;
  logic       s_pipe_reset;
  logic [7:0] s_dump_addr;
  logic [7:0] s_dump_data;
  logic       s_tx_start;
  logic [7:0] s_tx_data;
  logic       s_tx_done;
  logic       s_busy;

  int checks   = 0;
  int failures = 0;

  int pe_cycles = 0;
  int pr_cycles = 0;
  int ts_count  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] last_tx = 8'd0;
  logic [7:0] exp_byte;
  int         tx_cnt = 0;

  debug_run_controller u_dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .halt       (halt),
    .pipe_enable(pipe_enable),
    .pipe_reset (pipe_reset),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .busy       (busy)
  );

  debug_run_controller #(
    .DUMP_BYTES(1),
    .RST_CYCLES(1)
  ) u_small (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (s_rx_data),
    .rx_done    (s_rx_done),
    .halt       (s_halt),
    .pipe_enable(s_pipe_enable),
    .pipe_reset (s_pipe_reset),
    .dump_addr  (s_dump_addr),
    .dump_data  (s_dump_data),
    .tx_start   (s_tx_start),
    .tx_data    (s_tx_data),
    .tx_done    (s_tx_done),
    .busy       (s_busy)
  );

  // Debug memory model: each byte is its address XOR 0xA5.
  assign dump_data   = dump_addr ^ 8'hA5;
  assign s_dump_data = s_dump_addr ^ 8'hA5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter model: tx_done pulses 5 cycles after each tx_start.
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (tx_cnt > 0) begin
      tx_cnt = tx_cnt - 1;
      if (tx_cnt == 0) tx_done = 1'b1;
    end
    if (tx_start && !reset) tx_cnt = 5;
  end

  // Monitor: samples settled outputs shortly after each falling edge.
  always begin
    @(negedge clk);
    #2;
    if (!reset) begin
      if (pipe_enable) pe_cycles++;
      if (pipe_reset)  pr_cycles++;
      checks++;
      if ((pipe_enable && pipe_reset) !== 1'b0) begin
        failures++;
        $display("[TB] FAIL enable_and_reset_overlap: pipe_enable=%b pipe_reset=%b, required not both high",
                 pipe_enable, pipe_reset);
      end
      if (tx_start) begin
        ts_count++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_tx_start: tx_data=%02h with empty scoreboard", tx_data);
        end else begin
          exp_byte = exp_q.pop_front();
          last_tx  = exp_byte;
          if (tx_data !== exp_byte) begin
            failures++;
            $display("[TB] FAIL dump_byte: got %02h, required %02h", tx_data, exp_byte);
          end
        end
      end
      if (tx_done && busy) begin
        checks++;
        if (tx_data !== last_tx) begin
          failures++;
          $display("[TB] FAIL tx_data_hold: got %02h at tx_done, required %02h", tx_data, last_tx);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic push_dump(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(8'(i) ^ 8'hA5);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_counts();
    pe_cycles = 0;
    pr_cycles = 0;
    ts_count  = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (pipe_enable !== 1'b0) begin failures++; $display("[TB] FAIL reset_pipe_enable: got %b, required 0", pipe_enable); end
    checks++;
    if (pipe_reset !== 1'b0) begin failures++; $display("[TB] FAIL reset_pipe_reset: got %b, required 0", pipe_reset); end
    checks++;
    if (tx_start !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_start: got %b, required 0", tx_start); end
    checks++;
    if (tx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_tx_data: got %02h, required 00", tx_data); end
    checks++;
    if (dump_addr !== 8'h00) begin failures++; $display("[TB] FAIL reset_dump_addr: got %02h, required 00", dump_addr); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
    checks++;
    if (s_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_small_busy: got %b, required 0", s_busy); end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_step();
    bit ok;
    @(negedge clk);
    clear_counts();
    push_dump(16);
    send_byte(8'h73);
    #1;
    checks++;
    if ({pipe_enable, busy} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL step_enable_cycle: pipe_enable,busy=%b%b, required 11", pipe_enable, busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({pipe_enable, dump_addr} !== {1'b0, 8'h00}) begin
      failures++;
      $display("[TB] FAIL step_dload: pipe_enable=%b dump_addr=%02h, required 0 and 00", pipe_enable, dump_addr);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({tx_start, tx_data} !== {1'b1, 8'hA5}) begin
      failures++;
      $display("[TB] FAIL step_first_send: tx_start=%b tx_data=%02h, required 1 and a5", tx_start, tx_data);
    end
    wait_idle(400, ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL step_timeout: busy still %b, required 0", busy); end
    checks++;
    if (pe_cycles !== 1) begin failures++; $display("[TB] FAIL step_enable_count: got %0d, required 1", pe_cycles); end
    checks++;
    if (ts_count !== 16) begin failures++; $display("[TB] FAIL step_byte_count: got %0d, required 16", ts_count); end
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("[TB] FAIL step_scoreboard: %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_run_halt();
    bit ok;
    @(negedge clk);
    clear_counts();
    push_dump(16);
    send_byte(8'h63);
    repeat (19) @(negedge clk);
    halt = 1'b1;
    #1;
    checks++;
    if (pipe_enable !== 1'b0) begin failures++; $display("[TB] FAIL halt_mask: pipe_enable=%b, required 0", pipe_enable); end
    wait_idle(400, ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL run_halt_timeout: busy still %b, required 0", busy); end
    checks++;
    if (pe_cycles !== 19) begin failures++; $display("[TB] FAIL run_enable_count: got %0d, required 19", pe_cycles); end
    checks++;
    if (ts_count !== 16) begin failures++; $display("[TB] FAIL run_byte_count: got %0d, required 16", ts_count); end
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("[TB] FAIL run_scoreboard: %0d left, required 0", exp_q.size()); end
    halt = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_pipe_reset();
    bit ok;
    @(negedge clk);
    clear_counts();
    send_byte(8'h72);
    #1;
    checks++;
    if (pipe_reset !== 1'b1) begin failures++; $display("[TB] FAIL prst_first_cycle: pipe_reset=%b, required 1", pipe_reset); end
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL prst_release: busy=%b at n+5, required 0", busy); end
    repeat (2) @(negedge clk);
    checks++;
    if (pr_cycles !== 4) begin failures++; $display("[TB] FAIL prst_idle_len: got %0d cycles, required 4", pr_cycles); end

    clear_counts();
    send_byte(8'h63);
    repeat (2) @(negedge clk);
    halt    = 1'b1;
    rx_data = 8'h72;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'h00;
    wait_idle(50, ok);
    halt = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL prst_run_timeout: busy still %b, required 0", busy); end
    checks++;
    if (pr_cycles !== 4) begin failures++; $display("[TB] FAIL prst_run_len: got %0d cycles, required 4", pr_cycles); end
    checks++;
    if (pe_cycles !== 2) begin failures++; $display("[TB] FAIL prst_run_enable: got %0d cycles, required 2", pe_cycles); end
    checks++;
    if (ts_count !== 0) begin failures++; $display("[TB] FAIL prst_no_dump: got %0d tx_start, required 0", ts_count); end
    @(negedge clk);
  endtask

  task automatic test_ignored();
    bit ok;
    int start_ts;
    @(negedge clk);
    clear_counts();
    send_byte(8'h41);
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL ignore_unknown: busy=%b, required 0", busy); end
    repeat (3) @(negedge clk);
    checks++;
    if (pe_cycles !== 0) begin failures++; $display("[TB] FAIL ignore_unknown_enable: got %0d, required 0", pe_cycles); end

    push_dump(16);
    send_byte(8'h73);
    start_ts = ts_count;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #3;
      if (ts_count > start_ts) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL ignore_first_send_timeout: tx_start count %0d, required >0", ts_count); end
    @(negedge clk);
    send_byte(8'h73);
    wait_idle(400, ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL ignore_dump_timeout: busy still %b, required 0", busy); end
    checks++;
    if (pe_cycles !== 1) begin failures++; $display("[TB] FAIL ignore_step_enable: got %0d, required 1", pe_cycles); end
    checks++;
    if (ts_count !== 16) begin failures++; $display("[TB] FAIL ignore_byte_count: got %0d, required 16", ts_count); end
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if ({busy, pe_cycles == 1} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL ignore_not_queued: busy=%b enable_cycles=%0d, required 0 and 1", busy, pe_cycles);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    int snap;
    @(negedge clk);
    clear_counts();
    push_dump(16);
    send_byte(8'h73);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #3;
      if (ts_count == 3) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL areset_third_send_timeout: tx_start count %0d, required 3", ts_count); end
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({pipe_enable, pipe_reset, tx_start, busy, tx_data, dump_addr} !== 20'h0) begin
      failures++;
      $display("[TB] FAIL areset_outputs: pe=%b pr=%b ts=%b busy=%b tx_data=%02h addr=%02h, required all 0",
               pipe_enable, pipe_reset, tx_start, busy, tx_data, dump_addr);
    end
    exp_q.delete();
    snap = ts_count;
    repeat (8) @(negedge clk);
    checks++;
    if ((tx_start !== 1'b0) || (ts_count !== snap)) begin
      failures++;
      $display("[TB] FAIL areset_no_send: tx_start=%b count=%0d, required 0 and %0d", tx_start, ts_count, snap);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    clear_counts();
    push_dump(16);
    send_byte(8'h73);
    wait_idle(400, ok);
    checks++;
    if (!ok) begin failures++; $display("[TB] FAIL areset_redump_timeout: busy still %b, required 0", busy); end
    checks++;
    if (ts_count !== 16) begin failures++; $display("[TB] FAIL areset_redump_count: got %0d, required 16", ts_count); end
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("[TB] FAIL areset_scoreboard: %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_small_build();
    int pe = 0;
    int ts = 0;
    int pr = 0;
    int done_cnt = 0;
    @(negedge clk);
    s_rx_data = 8'h73;
    s_rx_done = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      s_rx_done = 1'b0;
      s_tx_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) s_tx_done = 1'b1;
      end
      #1;
      if (s_pipe_enable) pe++;
      if (s_tx_start) begin
        ts++;
        done_cnt = 3;
        checks++;
        if ({s_tx_data, s_dump_addr} !== {8'hA5, 8'h00}) begin
          failures++;
          $display("[TB] FAIL small_byte: tx_data=%02h addr=%02h, required a5 and 00", s_tx_data, s_dump_addr);
        end
      end
    end
    s_tx_done = 1'b0;
    checks++;
    if (pe !== 1) begin failures++; $display("[TB] FAIL small_step_enable: got %0d, required 1", pe); end
    checks++;
    if (ts !== 1) begin failures++; $display("[TB] FAIL small_byte_count: got %0d, required 1", ts); end
    checks++;
    if (s_busy !== 1'b0) begin failures++; $display("[TB] FAIL small_step_idle: busy=%b, required 0", s_busy); end

    @(negedge clk);
    s_rx_data = 8'h72;
    s_rx_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      s_rx_done = 1'b0;
      #1;
      if (s_pipe_reset) pr++;
    end
    checks++;
    if (pr !== 1) begin failures++; $display("[TB] FAIL small_prst_len: got %0d cycles, required 1", pr); end
    checks++;
    if (s_busy !== 1'b0) begin failures++; $display("[TB] FAIL small_prst_idle: busy=%b, required 0", s_busy); end
  endtask

  initial begin
    reset     = 1'b1;
    rx_data   = 8'h00;
    rx_done   = 1'b0;
    halt      = 1'b0;
    s_rx_data = 8'h00;
    s_rx_done = 1'b0;
    s_halt    = 1'b0;
    s_tx_done = 1'b0;

    test_reset();
    test_step();
    test_run_halt();
    test_pipe_reset();
    test_ignored();
    test_async_reset();
    test_small_build();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
